// File: rtl/hilo_muldiv_ctrl.sv
// Purpose: sequential control and HI/LO result registers for the ALU MUL/DIV path.
//   It registers operands for an external combinational multiplier and captures its product.
//   It also runs a signed restoring divide that produces one quotient bit per cycle.
// Latency: a multiply takes 2 edges from the start edge to the done cycle.
//   A divide takes 34 edges. A divide by zero takes 1 edge.
// Backpressure: start is accepted only in IDLE. A start seen while busy is dropped and not queued.
// Ports:
//   clk_i, clr_n_i            clock and asynchronous active-low reset
//   start_i, op_i, a_i, b_i   request pulse, op select (0 = mul, 1 = div) and operands
//   mul_a_o, mul_b_o, mul_p_i registered operands to the multiplier and its signed product
//   hi_o, lo_o                HI (product high half or remainder), LO (product low half or quotient)
//   busy_o, done_o            busy is high whenever not IDLE; done is a one-cycle result strobe
//   div_by_zero_o             sticky flag for the last operation
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk_i,
    input  logic                 clr_n_i,
    input  logic                 start_i,
    input  logic                 op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [WIDTH-1:0]     mul_a_o,
    output logic [WIDTH-1:0]     mul_b_o,
    input  logic [2*WIDTH-1:0]   mul_p_i,
    output logic [WIDTH-1:0]     hi_o,
    output logic [WIDTH-1:0]     lo_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 div_by_zero_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_CAP  = 3'd1;
    localparam logic [2:0] S_DIV_ITER = 3'd2;
    localparam logic [2:0] S_DIV_FIX  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder (unsigned)
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;   // |divisor|
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d;     // dividend sign
    logic             sb_q, sb_d;     // divisor sign
    logic             dbz_q, dbz_d;

    // Magnitudes of the raw inputs. For the most negative value the
    // two's-complement negation wraps back to itself, which is exactly
    // its correct unsigned magnitude.
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    assign a_abs = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_abs = b_i[WIDTH-1] ? -b_i : b_i;

    // One restoring step: bring the next dividend bit into the remainder,
    // then trial-subtract the divisor in WIDTH+1 bits so the borrow is visible.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign trial_ok = ~trial[WIDTH];

    // Sign fix-up for the final result. Truncation is toward zero, so the
    // quotient sign is the xor of the operand signs. The remainder follows
    // the dividend.
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] rem_signed;
    assign quo_signed = (sa_q ^ sb_q) ? -quo_q : quo_q;
    assign rem_signed = sa_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (!op_i) begin
                        mul_a_d = a_i;
                        mul_b_d = b_i;
                        dbz_d   = 1'b0;
                        state_d = S_MUL_CAP;
                    end else if (b_i == '0) begin
                        // A divide by zero returns immediately. The dividend
                        // passes through to HI, and LO saturates to all ones.
                        hi_d    = a_i;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        sa_d    = a_i[WIDTH-1];
                        sb_d    = b_i[WIDTH-1];
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_DIV_ITER;
                    end
                end
            end

            S_MUL_CAP: begin
                // The product settled during this cycle from the operands
                // that were registered on the previous edge.
                {hi_d, lo_d} = mul_p_i;
                state_d      = S_DONE;
            end

            S_DIV_ITER: begin
                if (trial_ok) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DIV_FIX;
                end
            end

            S_DIV_FIX: begin
                lo_d    = quo_signed;
                hi_d    = rem_signed;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dbz_q   <= dbz_d;
        end
    end

    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed test of hilo_muldiv_ctrl driving a behavioural 32x32 signed multiplier.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dbz;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int done_cnt = 0;
    int base_cnt = 0;

    // Behavioural stand-in for the combinational Booth multiplier.
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    assign ext_a = {{32{mul_a[31]}}, mul_a};
    assign ext_b = {{32{mul_b[31]}}, mul_b};
    assign mul_p = ext_a * ext_b;

    hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i         (clk),
        .clr_n_i       (clr_n),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .mul_a_o       (mul_a),
        .mul_b_o       (mul_b),
        .mul_p_i       (mul_p),
        .hi_o          (hi),
        .lo_o          (lo),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse. Afterwards lat counts the edges taken
    // so far, with the start edge itself counted as edge 1.
    task automatic start_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        lat   = 1;
    endtask

    // Bounded wait for done. An expired bound is reported through the
    // latency check made by the caller.
    task automatic wait_done();
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        start_op(o, x, y);
        wait_done();
    endtask

    initial begin
        clr_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_mul_a", 64'(mul_a), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_dbz", 64'(dbz), 64'h0);
        clr_n = 1'b1;
        tick();

        // 7 * -3 = -21
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mul1_lat", 64'(lat), 64'd2);
        chk("mul1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mul1_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("mul1_dbz", 64'(dbz), 64'h0);
        tick();
        chk("mul1_idle_busy", 64'(busy), 64'h0);
        chk("mul1_idle_done", 64'(done), 64'h0);

        // 100 / 7 = 14 r 2
        start_op(1'b1, 32'd100, 32'd7);
        chk("div1_busy", 64'(busy), 64'h1);
        wait_done();
        chk("div1_lat", 64'(lat), 64'd34);
        chk("div1_lo", 64'(lo), 64'd14);
        chk("div1_hi", 64'(hi), 64'd2);
        chk("div1_dbz", 64'(dbz), 64'h0);
        tick();

        // -100 / 7 = -14 r -2
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        chk("div2_lo", 64'(lo), 64'hFFFF_FFF2);
        chk("div2_hi", 64'(hi), 64'hFFFF_FFFE);
        tick();

        // 5 / 0
        run_op(1'b1, 32'd5, 32'd0);
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_hi", 64'(hi), 64'd5);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dz_flag", 64'(dbz), 64'h1);
        tick();
        tick();
        tick();
        chk("dz_hold_hi", 64'(hi), 64'd5);
        chk("dz_hold_flag", 64'(dbz), 64'h1);

        // 3 * 4 clears the sticky flag
        run_op(1'b0, 32'd3, 32'd4);
        chk("mul2_hi", 64'(hi), 64'h0);
        chk("mul2_lo", 64'(lo), 64'd12);
        chk("mul2_dbz", 64'(dbz), 64'h0);
        tick();

        // Overflow: most negative / -1
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'h0);
        chk("ovf_dbz", 64'(dbz), 64'h0);
        tick();

        // -7 / 2 = -3 r -1
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div3_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div3_hi", 64'(hi), 64'hFFFF_FFFF);
        tick();

        // A multiply start at iteration 10 of a divide must be dropped.
        start_op(1'b1, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
        end
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd2;
        b     = 32'd2;
        tick();
        lat++;
        start = 1'b0;
        wait_done();
        chk("ign_lat", 64'(lat), 64'd34);
        chk("ign_lo", 64'(lo), 64'd333);
        chk("ign_hi", 64'(hi), 64'd1);
        chk("ign_mul_a", 64'(mul_a), 64'd3);
        chk("ign_mul_b", 64'(mul_b), 64'd4);
        tick();
        chk("ign_no_restart", 64'(busy), 64'h0);

        // Reset at iteration 20 of a divide.
        start_op(1'b1, 32'd1000, 32'd3);
        for (int i = 0; i < 20; i++) tick();
        clr_n = 1'b0;
        #1;
        chk("mid_rst_hi", 64'(hi), 64'h0);
        chk("mid_rst_lo", 64'(lo), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_mul_a", 64'(mul_a), 64'h0);
        tick();
        clr_n = 1'b1;
        tick();
        chk("mid_rst_stay_idle", 64'(busy), 64'h0);
        run_op(1'b0, 32'd6, 32'd7);
        chk("post_rst_lat", 64'(lat), 64'd2);
        chk("post_rst_lo", 64'(lo), 64'd42);
        chk("post_rst_hi", 64'(hi), 64'h0);
        tick();

        // Back-to-back multiplies, the second starting in the first IDLE cycle.
        base_cnt = done_cnt;
        run_op(1'b0, 32'd5, 32'd6);
        chk("b2b1_lo", 64'(lo), 64'd30);
        tick();
        run_op(1'b0, 32'hFFFF_FFFE, 32'd3);
        chk("b2b2_lat", 64'(lat), 64'd2);
        chk("b2b2_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("b2b2_lo", 64'(lo), 64'hFFFF_FFFA);
        tick();
        tick();
        chk("b2b_done_pulses", 64'(done_cnt - base_cnt), 64'd2);
        chk("b2b_hold_lo", 64'(lo), 64'hFFFF_FFFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequential control and result-register stage for the ALU MUL/DIV path.
- It latches the operands and drives them into the combinational 32x32 Booth multiplier. It captures that multiplier's 64-bit product into the HI/LO registers.
- It also performs signed 32-bit division iteratively, one quotient bit per cycle, into the same HI/LO registers.
- It sits between the ALU operand buses and the HI/LO destination of the datapath.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each, product is 2*WIDTH.
- CNT_W, 6, width of the division iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = signed multiply, 1 = signed divide; sampled with start.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- mul_a  out  WIDTH  registered operand to the multiplier's a input.
- mul_b  out  WIDTH  registered operand to the multiplier's b input.
- mul_p  in  2*WIDTH  signed product from the multiplier; combinational from mul_a/mul_b; valid one cycle after they change.
- hi  out  WIDTH  HI register (product[63:32] or remainder).
- lo  out  WIDTH  LO register (product[31:0] or quotient).
- busy  out  1  high from the edge after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when hi/lo hold a new result.
- div_by_zero  out  1  sticky flag for the last operation; cleared at the next accepted start.

Behaviour:
- Reset (clr_n low, any time, including mid-operation):
  - State goes to IDLE.
  - hi, lo, mul_a, mul_b, the divider work registers and the counter go to 0.
  - busy, done and div_by_zero go to 0.
  - No partial result survives reset.
- States: IDLE, MUL_CAP, DIV_ITER, DIV_FIX, DONE. busy = (state != IDLE); done = (state == DONE). Both are decoded from the registered state.
- IDLE:
  - start=1, op=0 at edge k: mul_a<=a, mul_b<=b, div_by_zero<=0, go to MUL_CAP.
  - start=1, op=1, b!=0: latch |a| and |b| and the signs of a and b, clear remainder and counter, div_by_zero<=0, go to DIV_ITER.
  - start=1, op=1, b==0: hi<=a, lo<=all ones, div_by_zero<=1, go directly to DONE.
  - start=0: hold all registers.
- MUL_CAP: at edge k+1, {hi,lo}<=mul_p, go to DONE. done is high for the cycle after edge k+1, so multiply latency is 2 edges.
- DIV_ITER: unsigned restoring division, one bit per edge.
  - Shift {rem,quo} left 1.
  - Trial-subtract |b| from the WIDTH+1-bit remainder; if it is non-negative, keep it and set the quotient LSB.
  - counter+1; after WIDTH iterations (edge k+32), go to DIV_FIX.
- DIV_FIX, at edge k+33:
  - lo <= quo, negated if sign(a) xor sign(b).
  - hi <= rem, negated if sign(a).
  - Then go to DONE.
  - Result is truncation toward zero; the remainder takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0, div_by_zero=0.
- DONE: lasts exactly one cycle, returns to IDLE unconditionally. start in DONE is ignored.
- start while busy is ignored, with no queuing. Changes to op, a or b while busy have no effect.
- start may be asserted in the first IDLE cycle after DONE (back-to-back operations).
- hi/lo change only on the capture edge (MUL_CAP, DIV_FIX, or the div-by-zero start edge) or on reset. They hold across IDLE indefinitely.
- mul_a/mul_b change only when a multiply is accepted; they hold otherwise, including during divides.

Test Plan:
- Reset, then multiply a=7, b=0xFFFFFFFD (-3) → done 2 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
- Divide a=100, b=7 → busy for 34 cycles; done pulse after edge k+33; lo=14, hi=2. Repeat with a=-100 → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- Divide a=5, b=0 → done one edge after start; hi=5, lo=0xFFFFFFFF, div_by_zero=1. A following multiply 3*4 clears the flag → hi=0, lo=12.
- Divide 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0. Also 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Start a divide; assert start with op=0 at iteration 10 → ignored, divide result unchanged. Then pull clr_n low at iteration 20 → hi=lo=0, busy=0 immediately; next multiply completes normally.
- Back-to-back: multiply, start again in the first IDLE cycle after done → second result captured; done pulses exactly once per operation.
